// File: rtl/fp_mul.sv
// Three-stage binary32 multiplier with a global-enable valid/ready pipe.
// Denormals flush to zero; the product is truncated (round toward zero).
module fp_mul (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A_FP,
  input  logic [31:0] B_FP,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] P_FP
);

  typedef struct packed {
    logic              sign;
    logic              nan;
    logic              inf;
    logic              zero;
    logic signed [9:0] e;
  } cls_t;

  logic        advance;
  logic        s1_v;
  logic        s2_v;
  cls_t        s1_c;
  cls_t        s2_c;
  logic [23:0] s1_ma;
  logic [23:0] s1_mb;
  logic [47:0] s2_p;

  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [22:0] ma;
  logic [22:0] mb;
  logic        a_zero;
  logic        b_zero;
  logic        a_inf;
  logic        b_inf;
  logic        a_nan;
  logic        b_nan;
  cls_t        c_in;

  logic signed [9:0] e_n;
  logic [22:0]       m_n;
  logic [31:0]       pk;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  assign ea = A_FP[30:23];
  assign eb = B_FP[30:23];
  assign ma = A_FP[22:0];
  assign mb = B_FP[22:0];

  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hFF) && (ma == 23'h0);
  assign b_inf  = (eb == 8'hFF) && (mb == 23'h0);
  assign a_nan  = (ea == 8'hFF) && (ma != 23'h0);
  assign b_nan  = (eb == 8'hFF) && (mb != 23'h0);

  always_comb begin
    c_in      = '0;
    c_in.sign = A_FP[31] ^ B_FP[31];
    c_in.nan  = a_nan | b_nan
              | (a_inf & b_zero)
              | (a_zero & b_inf);
    c_in.inf  = a_inf | b_inf;
    c_in.zero = a_zero | b_zero;
    c_in.e    = $signed({2'b00, ea})
              + $signed({2'b00, eb})
              - 10'sd127;
  end

  // Data path carries no reset; only valid bits and P_FP do.
  always_ff @(posedge clock) begin
    if (advance) begin
      s1_c  <= c_in;
      s1_ma <= {1'b1, ma};
      s1_mb <= {1'b1, mb};
      s2_c  <= s1_c;
      s2_p  <= s1_ma * s1_mb;
    end
  end

  always_comb begin
    if (s2_p[47]) begin
      m_n = s2_p[46:24];
      e_n = s2_c.e + 10'sd1;
    end else begin
      m_n = s2_p[45:23];
      e_n = s2_c.e;
    end
  end

  always_comb begin
    if (s2_c.nan)
      pk = 32'h7FC0_0000;
    else if (s2_c.inf)
      pk = {s2_c.sign, 8'hFF, 23'h0};
    else if (s2_c.zero)
      pk = {s2_c.sign, 31'h0};
    else if (e_n >= 10'sd255)
      pk = {s2_c.sign, 8'hFF, 23'h0};
    else if (e_n <= 10'sd0)
      pk = {s2_c.sign, 31'h0};
    else
      pk = {s2_c.sign, e_n[7:0], m_n};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      out_valid <= 1'b0;
      P_FP      <= 32'h0;
    end else if (advance) begin
      s1_v      <= in_valid;
      s2_v      <= s1_v;
      out_valid <= s2_v;
      if (s2_v)
        P_FP <= pk;
    end
  end

endmodule
